// File: rtl/im_loader_pkg.sv
//============================================================================
// Module : im_loader_pkg
// Brief  : Constants and state encoding shared by the instruction-memory
//          loader, the instruction RAM and the CPU decoder.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
// Contents:
//   IM_AW / IM_OPW / IM_WW   address, opcode and word widths
//   CMD_DATA / CMD_END       frame command codes carried in HI[7:5]
//   ld_state_t               loader FSM state encoding
//   cmd_known()              true for a command the loader understands
//============================================================================
`default_nettype none

package im_loader_pkg;

  localparam int IM_AW  = 8;
  localparam int IM_OPW = 5;
  localparam int IM_WW  = IM_OPW + 8;

  localparam logic [2:0] CMD_DATA = 3'b000;
  localparam logic [2:0] CMD_END  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } ld_state_t;

  function automatic logic cmd_known(input logic [2:0] cmd);
    return (cmd == CMD_DATA) || (cmd == CMD_END);
  endfunction

endpackage

`default_nettype wire

// File: rtl/im_loader.sv
//============================================================================
// Module : im_loader
// Brief  : Writer side of the instruction memory. Accepts a valid/ready
//          byte stream, packs HI/LO byte pairs into {opcode, operand} words
//          and writes them to consecutive addresses starting at 0. Holds the
//          CPU while a load is in progress.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
// Build option:
//   IM_LOADER_CKSUM_EN  when defined, the LO byte of the END frame must equal
//                       the mod-256 sum of all DATA bytes, else the load
//                       ends in error.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle pulse: begin a load at address 0
//   in_data/in_valid      byte stream in
//   in_ready              byte accepted this cycle when also in_valid
//   we/waddr/wdata        instruction RAM write port (we is a 1-cycle pulse)
//   cpu_hold              high while a load is in progress
//   done / err            sticky completion / error flags, cleared by start
//   count                 words written in the current/last load (0..2**AW)
//============================================================================
`default_nettype none

module im_loader
  import im_loader_pkg::*;
#(
  parameter int AW  = IM_AW,
  parameter int OPW = IM_OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           we,
  output logic [AW-1:0]  waddr,
  output logic [OPW+7:0] wdata,
  output logic           cpu_hold,
  output logic           done,
  output logic           err,
  output logic [AW:0]    count
);

  // Count value meaning "memory full": 2**AW words written.
  localparam logic [AW:0] c_full = {1'b1, {AW{1'b0}}};

  ld_state_t      r_state;
  ld_state_t      w_next;
  logic [7:0]     r_hi;
  logic [AW-1:0]  r_waddr;
  logic [OPW+7:0] r_wdata;
  logic [AW:0]    r_count;
  logic           r_done;
  logic           r_err;
  logic           w_xfer;
  logic           w_hi_is_data;
  logic           w_hi_is_end;
`ifdef IM_LOADER_CKSUM_EN
  logic [7:0]     r_sum;
`endif

  assign w_xfer       = in_valid & in_ready;
  assign w_hi_is_data = (r_hi[7:5] == CMD_DATA);
  assign w_hi_is_end  = (r_hi[7:5] == CMD_END);

  assign in_ready = (r_state == ST_HI) || (r_state == ST_LO);
  assign we       = (r_state == ST_WR);
  // The CPU is released on the same edge that publishes done/err.
  assign cpu_hold = (r_state != ST_IDLE);
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign count    = r_count;
  assign done     = r_done;
  assign err      = r_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_HI;
      end
      ST_HI: begin
        if (w_xfer) w_next = cmd_known(in_data[7:5]) ? ST_LO : ST_ERR;
      end
      ST_LO: begin
        if (w_xfer) begin
          if (w_hi_is_end) begin
`ifdef IM_LOADER_CKSUM_EN
            w_next = (in_data == r_sum) ? ST_DONE : ST_ERR;
`else
            w_next = ST_DONE;
`endif
          end else if (r_count == c_full) begin
            // A DATA word with no room left is rejected without a write.
            w_next = ST_ERR;
          end else begin
            w_next = ST_WR;
          end
        end
      end
      ST_WR:   w_next = ST_HI;
      ST_DONE: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hi    <= 8'h00;
      r_waddr <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef IM_LOADER_CKSUM_EN
      r_sum   <= 8'h00;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
            r_waddr <= '0;
`ifdef IM_LOADER_CKSUM_EN
            r_sum   <= 8'h00;
`endif
          end
        end
        ST_HI: begin
          if (w_xfer) begin
            r_hi <= in_data;
`ifdef IM_LOADER_CKSUM_EN
            if (in_data[7:5] == CMD_DATA) r_sum <= r_sum + in_data;
`endif
          end
        end
        ST_LO: begin
          if (w_xfer && w_hi_is_data && (r_count != c_full)) begin
            r_wdata <= {r_hi[OPW-1:0], in_data};
`ifdef IM_LOADER_CKSUM_EN
            r_sum   <= r_sum + in_data;
`endif
          end
        end
        ST_WR: begin
          r_count <= r_count + 1'b1;
          // The last word of a full memory leaves waddr at the top address
          // instead of wrapping back to 0.
          if (r_waddr != {AW{1'b1}}) r_waddr <= r_waddr + 1'b1;
        end
        ST_DONE: r_done <= 1'b1;
        ST_ERR:  r_err  <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none

module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        we;
  logic [7:0]  waddr;
  logic [12:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [8:0]  count;

  im_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err),
    .count    (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [20:0] wlog[$];   // observed writes {addr, data}
  logic [20:0] exp_w[$];  // expected writes {addr, data}
  logic [7:0]  bytes[$];  // frame byte stream for the next load
  logic [7:0]  gen_sum;
  int          exp_count;
  bit          exp_done;
  bit          exp_err;
  int          n_used;

  always @(negedge clk) if (we === 1'b1) wlog.push_back({waddr, wdata});

  // Reference model: walks the byte stream word by word using the frame
  // rules and decides which bytes the loader consumes and what it writes.
  task automatic model();
    int         cnt;
    int         i;
    logic [7:0] sum;
    logic [7:0] hi;
    logic [7:0] lo;
    cnt = 0; sum = 8'h00; i = 0;
    exp_w.delete(); exp_done = 0; exp_err = 0; n_used = 0;
    while (i < bytes.size()) begin
      hi = bytes[i];
      n_used = i + 1;
      if (hi[7:5] != 3'b000 && hi[7:5] != 3'b111) begin exp_err = 1; break; end
      if (i + 1 >= bytes.size()) break;
      lo = bytes[i+1];
      n_used = i + 2;
      if (hi[7:5] == 3'b111) begin
`ifdef IM_LOADER_CKSUM_EN
        exp_err  = (lo != sum);
        exp_done = !exp_err;
`else
        exp_done = 1;
`endif
        break;
      end
      if (cnt == 256) begin exp_err = 1; break; end
      exp_w.push_back({cnt[7:0], hi[4:0], lo});
      cnt = cnt + 1;
      sum = 8'(sum + hi + lo);
      i = i + 2;
    end
    exp_count = cnt;
  endtask

  task automatic new_frame();
    bytes.delete();
    gen_sum = 8'h00;
  endtask

  task automatic push_data(input int n);
    logic [7:0] hi;
    logic [7:0] lo;
    for (int k = 0; k < n; k++) begin
      hi = {3'b000, 5'($urandom_range(0, 31))};
      lo = 8'($urandom);
      bytes.push_back(hi);
      bytes.push_back(lo);
      gen_sum = 8'(gen_sum + hi + lo);
    end
  endtask

  task automatic push_end(input bit good);
    bytes.push_back({3'b111, 5'($urandom_range(0, 31))});
    bytes.push_back(good ? gen_sum : 8'(gen_sum + 8'($urandom_range(1, 255))));
  endtask

  // All tasks start and end at a negedge.
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 50; k++) begin
      if (in_ready === 1'b1) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        return;
      end
      @(negedge clk);
    end
    checks++; failures++;
    $display("FAIL send_byte: in_ready stayed %b for byte %h, required 1", in_ready, b);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 20; k++) begin
      if (cpu_hold === 1'b0) break;
      @(negedge clk);
    end
    if (k == 20) begin
      checks++; failures++;
      $display("FAIL %s idle timeout: cpu_hold=%b required 0", tag, cpu_hold);
    end
  endtask

  task automatic check_result(input string tag);
    int bad;
    checks++;
    if (wlog.size() !== exp_w.size()) begin
      failures++;
      $display("FAIL %s write count: got %0d required %0d", tag, wlog.size(), exp_w.size());
    end else begin
      bad = -1;
      foreach (exp_w[k]) if (bad < 0 && wlog[k] !== exp_w[k]) bad = k;
      checks++;
      if (bad >= 0) begin
        failures++;
        $display("FAIL %s write %0d: got addr/data %h required %h", tag, bad, wlog[bad], exp_w[bad]);
      end
    end
    checks++;
    if ({done, err, cpu_hold, count} !== {exp_done, exp_err, 1'b0, 9'(exp_count)}) begin
      failures++;
      $display("FAIL %s status: got done=%b err=%b hold=%b count=%0d required done=%b err=%b hold=0 count=%0d",
               tag, done, err, cpu_hold, count, exp_done, exp_err, exp_count);
    end
  endtask

  task automatic run_load(input string tag, input bit mid_start);
    model();
    wlog.delete();
    pulse_start();
    checks++;
    if (cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL %s hold_at_start: got %b required 1", tag, cpu_hold);
    end
    for (int i = 0; i < n_used; i++) begin
      if (i == n_used - 1) begin
        checks++;
        if (cpu_hold !== 1'b1) begin
          failures++;
          $display("FAIL %s hold_mid_load: got %b required 1", tag, cpu_hold);
        end
      end
      send_byte(bytes[i]);
      if (mid_start && i == 5) pulse_start();
    end
    wait_idle(tag);
    check_result(tag);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({in_ready, we, waddr, wdata, cpu_hold, done, err, count} !== 35'd0) begin
      failures++;
      $display("FAIL %s: got rdy=%b we=%b waddr=%h wdata=%h hold=%b done=%b err=%b count=%0d required all 0",
               tag, in_ready, we, waddr, wdata, cpu_hold, done, err, count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    // Valid data while idle is neither accepted nor an error.
    wlog.delete();
    in_valid = 1'b1; in_data = 8'h40;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, err, cpu_hold} !== 3'b000 || wlog.size() != 0) begin
      failures++;
      $display("FAIL idle_valid: got rdy=%b err=%b hold=%b writes=%0d required 0 0 0 0",
               in_ready, err, cpu_hold, wlog.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    wlog.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if ({we, waddr, wdata} !== {1'b1, 8'h00, 13'h0000}) begin
      failures++;
      $display("FAIL basic_w0: got we=%b addr=%h data=%h required 1 00 0000", we, waddr, wdata);
    end
    send_byte(8'h01);
    send_byte(8'h05);
    checks++;
    if ({we, waddr, wdata} !== {1'b1, 8'h01, 13'h0105}) begin
      failures++;
      $display("FAIL basic_w1: got we=%b addr=%h data=%h required 1 01 0105", we, waddr, wdata);
    end
    send_byte(8'hE0);
    send_byte(8'h06);  // 00+00+01+05: valid checksum either way
    wait_idle("basic");
    exp_w.delete();
    exp_w.push_back({8'h00, 13'h0000});
    exp_w.push_back({8'h01, 13'h0105});
    exp_done = 1; exp_err = 0; exp_count = 2;
    check_result("basic");
  endtask

  task automatic test_seven_words();
    new_frame(); push_data(7); push_end(1);
    run_load("seven", 1'b1);
  endtask

  task automatic test_bad_cmd();
    new_frame(); bytes.push_back(8'h40); bytes.push_back(8'h11);
    run_load("bad_40", 1'b0);
    new_frame(); push_data($urandom_range(1, 4));
    bytes.push_back({3'($urandom_range(1, 6)), 5'($urandom_range(0, 31))});
    bytes.push_back(8'($urandom));
    run_load("bad_rand", 1'b0);
  endtask

  task automatic test_empty();
    new_frame(); push_end(1);
    run_load("empty", 1'b0);
  endtask

  task automatic test_overflow();
    new_frame(); push_data(257); push_end(1);
    run_load("overflow", 1'b0);
    checks++;
    if (waddr !== 8'hFF) begin
      failures++;
      $display("FAIL overflow_waddr: got %h required ff", waddr);
    end
  endtask

  task automatic test_rst_mid();
    new_frame(); push_data(3);
    bytes.push_back(8'h0A);
    model();
    wlog.delete();
    pulse_start();
    for (int i = 0; i < bytes.size(); i++) send_byte(bytes[i]);
    checks++;
    if (wlog.size() != 3 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: got writes=%0d rdy=%b required 3 1", wlog.size(), in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    new_frame(); push_data($urandom_range(1, 5)); push_end(1);
    run_load("after_rst", 1'b0);
  endtask

  task automatic test_cksum();
    new_frame();
    bytes = '{8'h03, 8'h00, 8'h08, 8'h01, 8'hE0, 8'h0C};
    run_load("cksum_good", 1'b0);
    bytes = '{8'h03, 8'h00, 8'h08, 8'h01, 8'hE0, 8'h0D};
    run_load("cksum_bad", 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      new_frame();
      push_data($urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0)
        bytes.push_back({3'($urandom_range(1, 6)), 5'($urandom_range(0, 31))});
      push_end($urandom_range(0, 1) == 1);
      run_load("random", n[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seven_words();
    test_bad_cmd();
    test_empty();
    test_overflow();
    test_rst_mid();
    test_cksum();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
